// File: rtl/input4_and_b.sv
// input4_and_b: registered two-level AND tree (e=a&b, f=c&d, g=e&f) with a valid flag
// and a saturating count of accepted all-ones results.
module input4_and_b #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic             out_valid,
  output logic [CNT_W-1:0] match_cnt
);
  logic [WIDTH-1:0] ab, cd, abcd;
  logic hit, sat;
  // g comes from this cycle's operands, not from the registered e and f
  always_comb begin
    ab = a & b;
    cd = c & d;
    abcd = ab & cd;
    hit = in_valid && (&abcd);
    sat = &match_cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e <= '0;
      f <= '0;
      g <= '0;
      out_valid <= 1'b0;
      match_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        e <= ab;
        f <= cd;
        g <= abcd;
      end
      if (hit && !sat) match_cnt <= match_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_input4_and_b.sv
// tb_input4_and_b: three configurations (1-bit/8-bit count, 1-bit/2-bit count, 4-bit/8-bit count)
// driven together and compared against a vector-count reference model.
module tb_input4_and_b;
  logic clk, rst_n, in_valid;
  logic [3:0] a, b, c, d;
  logic e1, f1, g1, ov1;
  logic [7:0] cnt1;
  logic e2, f2, g2, ov2;
  logic [1:0] cnt2;
  logic [3:0] e4, f4, g4;
  logic ov4;
  logic [7:0] cnt4;
  int checks = 0;
  int errors = 0;
  logic [3:0] x_e, x_f, x_g;
  logic x_ov;
  int n1, n4;

  input4_and_b #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
    .e(e1), .f(f1), .g(g1), .out_valid(ov1), .match_cnt(cnt1));
  input4_and_b #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
    .e(e2), .f(f2), .g(g2), .out_valid(ov2), .match_cnt(cnt2));
  input4_and_b #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .e(e4), .f(f4), .g(g4), .out_valid(ov4), .match_cnt(cnt4));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic check_all();
    chk("u1_e", 32'(e1), 32'(x_e[0]));
    chk("u1_f", 32'(f1), 32'(x_f[0]));
    chk("u1_g", 32'(g1), 32'(x_g[0]));
    chk("u1_ov", 32'(ov1), 32'(x_ov));
    chk("u1_cnt", 32'(cnt1), 32'(clip(n1, 255)));
    chk("u2_g", 32'(g2), 32'(x_g[0]));
    chk("u2_ov", 32'(ov2), 32'(x_ov));
    chk("u2_cnt", 32'(cnt2), 32'(clip(n1, 3)));
    chk("u4_e", 32'(e4), 32'(x_e));
    chk("u4_f", 32'(f4), 32'(x_f));
    chk("u4_g", 32'(g4), 32'(x_g));
    chk("u4_ov", 32'(ov4), 32'(x_ov));
    chk("u4_cnt", 32'(cnt4), 32'(clip(n4, 255)));
  endtask

  // Model counts matching vectors since reset; saturation is applied only when comparing.
  task automatic step(input logic r, input logic v, input logic [3:0] ia, ib, ic, id);
    rst_n = r;
    in_valid = v;
    a = ia;
    b = ib;
    c = ic;
    d = id;
    @(posedge clk);
    if (!r) begin
      x_e = 4'h0;
      x_f = 4'h0;
      x_g = 4'h0;
      x_ov = 1'b0;
      n1 = 0;
      n4 = 0;
    end else begin
      x_ov = v;
      if (v) begin
        x_e = ia & ib;
        x_f = ic & id;
        x_g = ia & ib & ic & id;
        if (ia[0] && ib[0] && ic[0] && id[0]) n1++;
        if ((ia & ib & ic & id) == 4'hf) n4++;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    logic [3:0] ra, rb, rc, rd;
    rst_n = 1'b0;
    in_valid = 1'b0;
    {a, b, c, d} = '0;
    // reset with a valid all-ones vector must discard it
    step(1'b0, 1'b1, 4'hf, 4'hf, 4'hf, 4'hf);
    step(1'b0, 1'b1, 4'hf, 4'hf, 4'hf, 4'hf);
    chk("rst_g", 32'(g1), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    // exhaustive 1-bit sweep, replicated across lanes
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, {4{i[3]}}, {4{i[2]}}, {4{i[1]}}, {4{i[0]}});
    chk("sweep_cnt", 32'(cnt1), 32'd1);
    chk("sweep_g_last", 32'(g1), 32'd1);
    // hold: valid low with zero operands keeps previous result
    step(1'b1, 1'b1, 4'hf, 4'hf, 4'hf, 4'hf);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("hold_efg", 32'({e1, f1, g1}), 32'b111);
      chk("hold_ov", 32'(ov1), 32'd0);
      chk("hold_cnt", 32'(cnt1), 32'd2);
    end
    // saturation of the 2-bit counter
    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'hf, 4'hf, 4'hf, 4'hf);
      chk("sat_cnt2", 32'(cnt2), 32'(sat_exp[i]));
    end
    // multi-lane directed vector
    step(1'b1, 1'b1, 4'b1111, 4'b1010, 4'b1100, 4'b1111);
    chk("ml_e", 32'(e4), 32'b1010);
    chk("ml_f", 32'(f4), 32'b1100);
    chk("ml_g", 32'(g4), 32'b1000);
    chk("ml_cnt", 32'(cnt4), 32'd5);
    // randomized traffic, biased toward ones, with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      ra = 4'($urandom | $urandom);
      rb = 4'($urandom | $urandom);
      rc = 4'($urandom | $urandom);
      rd = 4'($urandom | $urandom);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), ra, rb, rc, rd);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input4_and_b.md
INPUT4_AND_B -- requirements
Module: input4_and_b

Interface
REQ-001 Parameter WIDTH, default 1: lane width of every data input and output; each bit position is an independent lane.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset; one clock, reset is synchronous and active-low.
REQ-005 Port in_valid, input, 1: qualifies a, b, c, d in the current cycle.
REQ-006 Port a, input, WIDTH: operand 1.
REQ-007 Port b, input, WIDTH: operand 2.
REQ-008 Port c, input, WIDTH: operand 3.
REQ-009 Port d, input, WIDTH: operand 4.
REQ-010 Port e, output, WIDTH: registered first-stage AND, a & b.
REQ-011 Port f, output, WIDTH: registered first-stage AND, c & d.
REQ-012 Port g, output, WIDTH: registered 4-input AND, (a & b) & (c & d).
REQ-013 Port out_valid, output, 1: e, f and g hold a freshly captured result.
REQ-014 Port match_cnt, output, CNT_W: saturating count of accepted vectors whose g is all-ones.

Function
REQ-015 The block SHALL compute e = a & b, f = c & d and g = e & f bitwise per lane, as a two-level 2-input AND tree.
REQ-016 g SHALL be derived from the same sampled operands as e and f in the same cycle, never from previously registered e and f.
REQ-017 When in_valid=1 at a rising edge, e, f and g SHALL update from that cycle's a, b, c, d, giving a latency of 1 cycle.
REQ-018 When in_valid=1 at a rising edge, out_valid SHALL be 1 in the following cycle.
REQ-019 When in_valid=0 at a rising edge, e, f and g SHALL hold their previous values and out_valid SHALL be 0 in the following cycle.
REQ-020 No backpressure: a new vector SHALL be accepted on every cycle with in_valid=1, back-to-back with no bubble.
REQ-021 match_cnt SHALL increment by 1 on each accepted vector whose computed g equals all-ones (all lanes 1).
REQ-022 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 Inputs with X or Z values SHALL NOT be given any defined behaviour; the bench drives known values only.
REQ-024 There SHALL be no combinational path from any input to any output.

Reset
REQ-025 While rst_n=0 at a rising edge, e, f and g SHALL be set to all-zeros, out_valid to 0 and match_cnt to 0, regardless of in_valid.
REQ-026 Reset SHALL override a simultaneous in_valid=1, and the vector presented in that cycle SHALL be discarded.
REQ-027 The first vector SHALL be accepted at the first rising edge where rst_n=1 and in_valid=1.
REQ-028 Asserting reset mid-stream SHALL clear all state at the next edge with no partial result retained.

Verification
REQ-029 Exhaustive sweep, WIDTH=1: all 16 abcd combinations 0000..1111, each held 20 ns with in_valid=1 -> e=a&b, f=c&d one cycle later; g=1 only for 1111; match_cnt=1 at end.
REQ-030 Hold: accept abcd=1111, then in_valid=0 with abcd=0000 for 3 cycles -> e=f=g=1 held, out_valid=0, match_cnt unchanged.
REQ-031 Reset priority: rst_n=0 with in_valid=1 and abcd=1111 -> next cycle e=f=g=0, out_valid=0, match_cnt=0.
REQ-032 Saturation, CNT_W=2: 5 consecutive 1111 vectors -> match_cnt reads 1, 2, 3, 3, 3.
REQ-033 Multi-lane, WIDTH=4: a=4'b1111, b=4'b1010, c=4'b1100, d=4'b1111 -> e=4'b1010, f=4'b1100, g=4'b1000, match_cnt unchanged.
